// File: rtl/sevseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevseg_scan_driver
//
// Scan controller for a 4-digit common-anode seven-segment display. It picks
// one nibble of a 16-bit display value per scan slot and presents it to the
// downstream hex-to-segment decoder. In the same slot it drives the matching
// digit anode. New values are staged in a pending register. They are copied
// into the displayed (shadow) register only at a frame boundary, so a digit
// never shows a torn update.
//
// Optional feature (compile-time macro SEVSEG_LEADING_ZERO_BLANK_EN):
//   When the macro is defined, leading zero digits (3..1) of the shadow value
//   are blanked. Digit 0 is never blanked. When the macro is undefined, all
//   masked-in digits are shown, including leading zeros.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   ANODE_ON     anode level that lights a digit; off level is ~ANODE_ON
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   enable          1 = scanning; 0 = prescaler/index held, anodes off
//   load            one-cycle strobe capturing value_in
//   value_in[15:0]  digit3 = [15:12] ... digit0 = [3:0]
//   digit_mask[3:0] per-digit enable; 0 forces that anode off
//   digit_val[3:0]  nibble to the segment decoder (registered)
//   anode[3:0]      digit anode drives, bit i = digit i (registered)
//   update_pending  a loaded value is waiting for the frame boundary
//   frame_done      one-cycle pulse the cycle after each frame boundary
// -----------------------------------------------------------------------------
module sevseg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter logic        ANODE_ON    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  digit_mask,
    output logic [3:0]  digit_val,
    output logic [3:0]  anode,
    output logic        update_pending,
    output logic        frame_done
);

    localparam int unsigned       PCNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX  = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]        ANODE_OFF = {4{~ANODE_ON}};

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [15:0]       pending_q, pending_d;
    logic              pend_q, pend_d;
    logic [3:0]        digit_val_q, digit_val_d;
    logic [3:0]        anode_q, anode_d;
    logic              frame_done_q, frame_done_d;

    logic              tick_s;
    logic              boundary_s;
    logic [3:0]        blank_s;

    // Per-digit leading-zero blank flags, derived from the displayed value.
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        blank_s    = 4'b0000;
        blank_s[3] = (shadow_q[15:12] == 4'h0);
        blank_s[2] = (shadow_q[15:8]  == 8'h00);
        blank_s[1] = (shadow_q[15:4]  == 12'h000);
    end
`else
    always_comb begin
        blank_s = 4'b0000;
    end
`endif

    // Prescaler, digit index and frame-boundary detection.
    always_comb begin
        tick_s     = enable && (pcnt_q == PCNT_MAX);
        boundary_s = tick_s && (idx_q == 2'd3);
        pcnt_d     = pcnt_q;
        idx_d      = idx_q;
        if (tick_s) begin
            pcnt_d = '0;
            idx_d  = idx_q + 2'd1;
        end else if (enable) begin
            pcnt_d = pcnt_q + {{(PCNT_W-1){1'b0}}, 1'b1};
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // Load path: stage in pending, commit to shadow only at a frame boundary.
    // A load coinciding with the boundary bypasses pending entirely.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        if (boundary_s && load) begin
            shadow_d  = value_in;
            pending_d = value_in;
            pend_d    = 1'b0;
        end else if (boundary_s && pend_q) begin
            shadow_d = pending_q;
            pend_d   = 1'b0;
        end else if (load) begin
            pending_d = value_in;
            pend_d    = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    // Next output values; at most one anode bit is ever driven to ANODE_ON.
    always_comb begin
        frame_done_d = boundary_s;
        digit_val_d  = shadow_q[{idx_q, 2'b00} +: 4];
        anode_d      = ANODE_OFF;
        if (enable && digit_mask[idx_q] && !blank_s[idx_q]) begin
            anode_d[idx_q] = ANODE_ON;
        end else begin
            anode_d = ANODE_OFF;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q       <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= 16'h0000;
            pending_q    <= 16'h0000;
            pend_q       <= 1'b0;
            digit_val_q  <= 4'h0;
            anode_q      <= ANODE_OFF;
            frame_done_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_q       <= pend_d;
            digit_val_q  <= digit_val_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_val      = digit_val_q;
    assign anode          = anode_q;
    assign update_pending = pend_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// -----------------------------------------------------------------------------
// Testbench for sevseg_scan_driver (REFRESH_DIV = 4, ANODE_ON = 0).
// Every cycle a behavioural reference pushes the expected post-edge outputs
// into a scoreboard queue. The entry is popped and compared once the DUT has
// clocked. Directed checks on captured 16-cycle frame traces cover the scan
// order, the load timing, masking, enable hold and reset scenarios.
// -----------------------------------------------------------------------------
module tb_sevseg_scan_driver;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  digit_mask;
    logic [3:0]  digit_val;
    logic [3:0]  anode;
    logic        update_pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] dv;
        logic [3:0] an;
        logic       up;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    // reference model state
    int          m_pcnt    = 0;
    int          m_idx     = 0;
    logic [15:0] m_shadow  = 16'h0000;
    logic [15:0] m_pending = 16'h0000;
    logic        m_pend    = 1'b0;

    // captured frame traces
    logic [3:0] an_tr [16];
    logic [3:0] dv_tr [16];
    logic       fd_tr [16];
    logic       up_tr [16];

    sevseg_scan_driver #(
        .REFRESH_DIV (4),
        .ANODE_ON    (1'b0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .load           (load),
        .value_in       (value_in),
        .digit_mask     (digit_mask),
        .digit_val      (digit_val),
        .anode          (anode),
        .update_pending (update_pending),
        .frame_done     (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic tb_blank(input logic [15:0] s, input int i);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        if (i == 0) return 1'b0;
        return ((s >> (4 * i)) == 16'h0000);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_anode(input logic [15:0] s, input logic [3:0] mask, input int slot);
        logic [3:0] one;
        one = 4'b0001;
        if (mask[slot] && !tb_blank(s, slot)) return ~(one << slot);
        return 4'hF;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // one clock: predict, push, clock, pop and compare
    task automatic cyc();
        exp_t e;
        exp_t got;
        logic tick;
        logic bnd;
        tick = enable && (m_pcnt == 3);
        bnd  = tick && (m_idx == 3);
        if (rst) begin
            e.dv = 4'h0; e.an = 4'hF; e.up = 1'b0; e.fd = 1'b0;
            m_pcnt = 0; m_idx = 0; m_shadow = 16'h0000; m_pending = 16'h0000; m_pend = 1'b0;
        end else begin
            e.dv = 4'(m_shadow >> (4 * m_idx));
            e.an = 4'hF;
            if (enable && digit_mask[m_idx] && !tb_blank(m_shadow, m_idx)) e.an[m_idx] = 1'b0;
            e.fd = bnd;
            if (enable) m_pcnt = tick ? 0 : m_pcnt + 1;
            if (tick) m_idx = (m_idx + 1) % 4;
            if (bnd && load) begin
                m_shadow = value_in; m_pend = 1'b0;
            end else if (bnd && m_pend) begin
                m_shadow = m_pending; m_pend = 1'b0;
            end else if (load) begin
                m_pending = value_in; m_pend = 1'b1;
            end
            e.up = m_pend;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("sb_digit_val", digit_val, got.dv);
        chk("sb_anode", anode, got.an);
        chk("sb_update_pending", {3'b000, update_pending}, {3'b000, got.up});
        chk("sb_frame_done", {3'b000, frame_done}, {3'b000, got.fd});
    endtask

    task automatic trace16();
        for (int k = 0; k < 16; k++) begin
            cyc();
            an_tr[k] = anode;
            dv_tr[k] = digit_val;
            fd_tr[k] = frame_done;
            up_tr[k] = update_pending;
        end
    endtask

    // directed checks on a captured frame that started right after a boundary
    task automatic check_frame(input string tag, input logic [15:0] s, input logic [3:0] mask);
        logic [15:0] sv;
        for (int k = 0; k < 16; k++) begin
            sv = s >> (4 * (k / 4));
            chk({tag, "_anode"}, an_tr[k], exp_anode(s, mask, k / 4));
            chk({tag, "_digit_val"}, dv_tr[k], sv[3:0]);
            chk({tag, "_frame_done"}, {3'b000, fd_tr[k]}, (k == 15) ? 4'h1 : 4'h0);
        end
    endtask

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, "_wait_frame_done"}, {3'b000, frame_done}, 4'h1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; value_in = 16'h0000; digit_mask = 4'hF;

        // reset state
        cyc();
        cyc();
        chk("rst_anode", anode, 4'hF);
        chk("rst_digit_val", digit_val, 4'h0);
        chk("rst_frame_done", {3'b000, frame_done}, 4'h0);
        chk("rst_update_pending", {3'b000, update_pending}, 4'h0);

        // free-running scan, no load: digit 0 first, frame_done every 16 clk
        rst = 1'b0; enable = 1'b1;
        trace16();
        check_frame("scan0", 16'h0000, 4'hF);
        trace16();
        check_frame("scan1", 16'h0000, 4'hF);

        // mid-frame load of 1A2F
        cyc(); cyc(); cyc(); cyc(); cyc();
        load = 1'b1; value_in = 16'h1A2F;
        cyc();
        load = 1'b0;
        chk("load_pending_set", {3'b000, update_pending}, 4'h1);
        wait_fd("load1a2f");
        chk("load_pending_clear_with_fd", {3'b000, update_pending}, 4'h0);
        trace16();
        check_frame("show1a2f", 16'h1A2F, 4'hF);
        chk("show1a2f_first", dv_tr[0], 4'hF);
        chk("show1a2f_last", dv_tr[12], 4'h1);

        // two loads in one frame, last wins; then a load exactly on a boundary
        cyc(); cyc();
        load = 1'b1; value_in = 16'h1111; cyc(); load = 1'b0;
        cyc(); cyc(); cyc();
        load = 1'b1; value_in = 16'h2222; cyc(); load = 1'b0;
        chk("two_loads_pending", {3'b000, update_pending}, 4'h1);
        for (int k = 0; k < 9; k++) cyc();
        chk("two_loads_boundary_fd", {3'b000, frame_done}, 4'h1);
        chk("two_loads_boundary_clear", {3'b000, update_pending}, 4'h0);
        for (int k = 0; k < 15; k++) begin
            cyc();
            chk("frame2222_digit_val", digit_val, 4'h2);
        end
        load = 1'b1; value_in = 16'h3333;
        cyc();
        load = 1'b0;
        chk("boundary_load_fd", {3'b000, frame_done}, 4'h1);
        chk("boundary_load_no_pending", {3'b000, update_pending}, 4'h0);
        trace16();
        check_frame("show3333", 16'h3333, 4'hF);
        for (int k = 0; k < 16; k++) chk("show3333_no_pending", {3'b000, up_tr[k]}, 4'h0);

        // digit mask 0101
        digit_mask = 4'b0101;
        trace16();
        check_frame("mask0101", 16'h3333, 4'b0101);
        chk("mask0101_slot1_off", an_tr[5], 4'hF);
        chk("mask0101_slot2_on", an_tr[9], 4'b1011);

        // enable dropped mid-slot at idx 2, load while disabled stays pending
        digit_mask = 4'hF;
        for (int k = 0; k < 9; k++) cyc();
        enable = 1'b0; load = 1'b1; value_in = 16'hBEEF;
        cyc();
        load = 1'b0;
        chk("dis_anode_off", anode, 4'hF);
        chk("dis_pending", {3'b000, update_pending}, 4'h1);
        for (int k = 0; k < 9; k++) begin
            cyc();
            chk("dis_hold_anode", anode, 4'hF);
            chk("dis_hold_pending", {3'b000, update_pending}, 4'h1);
        end
        enable = 1'b1;
        cyc(); chk("resume_idx2_a", anode, 4'b1011);
        cyc(); chk("resume_idx2_b", anode, 4'b1011);
        cyc(); chk("resume_idx2_c", anode, 4'b1011);
        cyc(); chk("resume_idx3", anode, 4'b0111);

        // reset with a pending value: outputs return to reset, value discarded
        rst = 1'b1;
        cyc();
        chk("midrst_anode", anode, 4'hF);
        chk("midrst_digit_val", digit_val, 4'h0);
        chk("midrst_pending", {3'b000, update_pending}, 4'h0);
        chk("midrst_frame_done", {3'b000, frame_done}, 4'h0);
        rst = 1'b0;
        trace16();
        check_frame("after_rst", 16'h0000, 4'hF);
        for (int k = 0; k < 16; k++) chk("after_rst_no_pending", {3'b000, up_tr[k]}, 4'h0);

        // leading-zero behaviour: 00A5 then 0000
        load = 1'b1; value_in = 16'h00A5; cyc(); load = 1'b0;
        wait_fd("load00a5");
        trace16();
        check_frame("show00a5", 16'h00A5, 4'hF);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        chk("show00a5_slot2", an_tr[8], 4'hF);
        chk("show00a5_slot3", an_tr[12], 4'hF);
`else
        chk("show00a5_slot2", an_tr[8], 4'b1011);
        chk("show00a5_slot3", an_tr[12], 4'b0111);
`endif
        chk("show00a5_slot1", an_tr[4], 4'b1101);

        load = 1'b1; value_in = 16'h0000; cyc(); load = 1'b0;
        wait_fd("load0000");
        trace16();
        check_frame("show0000", 16'h0000, 4'hF);
        chk("show0000_slot0", an_tr[0], 4'b1110);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        chk("show0000_slot1", an_tr[4], 4'hF);
`else
        chk("show0000_slot1", an_tr[4], 4'b1101);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
